codec_init_sequencer: RTL and testbench
=======================================

Name: codec_init_sequencer

Overview:
- Produces the audio-codec (WM8731-style) register initialisation sequence for the I2C write master. Sits between reset/control logic and the I2C byte engine.
- Each time the I2C master signals it can take a new command (NewCom), the block issues the next {sub-address, data} pair with a one-cycle write strobe.
- After the last table entry it goes idle permanently until reset.

Parameters:
- NUM_CMDS, 11, number of entries in the init table; the table below defines all 11.

Ports:
- I2C_clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- NewCom  in  1  I2C master ready for a new command; only its rising edge is acted on.
- write  out  1  one-cycle strobe: SubAddrL/data hold a new command.
- SubAddrL  out  8  first I2C payload byte = {reg_addr[6:0], reg_val[8]}.
- data  out  8  second I2C payload byte = reg_val[7:0].

Behaviour:
- Interface (already decided): one clock, I2C_clk; reset is synchronous and active-high, port name reset.
- Reset:
  - write=0, SubAddrL=8'h00, data=8'h00, index=0, state=WAIT.
  - The NewCom-previous register resets to 0, so NewCom already high on the first cycle after reset counts as a rising edge.
  - Reset has priority over everything, including a simultaneous NewCom edge. Reset mid-sequence restarts from entry 0.
- Edge detect: rise = NewCom & ~NewCom_q, with NewCom_q registered every cycle.
- States:
  - WAIT: on rise, load SubAddrL/data from table[index], set write=1, increment index, go to ISSUE. If the incremented index equals NUM_CMDS, go to DONE after ISSUE.
  - ISSUE: write=0 (the strobe lasts exactly one cycle), return to WAIT or go to DONE.
  - DONE: write stays 0, outputs hold the last entry, and NewCom is ignored.
- Latency: NewCom sampled high (previously low) at edge k -> write=1 from edge k to edge k+1. Outputs are registered.
- SubAddrL and data hold their values between commands. They change only together with a write pulse.
- NewCom held high for many cycles produces exactly one command.
- A rise during ISSUE cannot occur (rise needs a low cycle first). Any rise in DONE is ignored.
- Table (index: addr,val -> SubAddrL,data):
  - 0: 0x0F,0x000 (reset) -> 1E,00
  - 1: 0x00,0x017 (L line in) -> 00,17
  - 2: 0x01,0x017 (R line in) -> 02,17
  - 3: 0x02,0x079 (L HP) -> 04,79
  - 4: 0x03,0x079 (R HP) -> 06,79
  - 5: 0x04,0x012 (analog path) -> 08,12
  - 6: 0x05,0x000 (digital path) -> 0A,00
  - 7: 0x06,0x000 (power down) -> 0C,00
  - 8: 0x07,0x002 (I2S 16-bit slave) -> 0E,02
  - 9: 0x08,0x000 (sampling) -> 10,00
  - 10: 0x09,0x001 (active) -> 12,01
- Index width: clog2(NUM_CMDS+1). Index never wraps.

Decomposition:
- Package codec_init_pkg: NUM_CMDS, register-address constants, 9-bit value constants, state enum {WAIT, ISSUE, DONE}.
- One sub-module codec_init_rom: combinational index -> {SubAddrL, data} lookup.
- Top level holds the edge detector, FSM and output registers.

Test Plan:
- Reset, then a one-cycle NewCom pulse -> one cycle later write=1 for exactly one cycle with SubAddrL=1E, data=00.
- 11 pulses spaced 9 cycles apart -> 11 write strobes in table order; the 11th gives SubAddrL=12, data=01.
- 35 pulses (the 11 above plus 24 more) -> no further writes after the 11th; SubAddrL=12, data=01 held.
- NewCom held high for 20 cycles -> exactly one write strobe.
- Reset asserted after entry 4 issued, then NewCom pulse -> write with 1E/00 (restart from entry 0). Outputs are 00/00 with write=0 during reset.
- NewCom rise in the same cycle as reset -> no write; the next pulse after reset yields entry 0.

Source files
------------

// File: rtl/codec_init_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : codec_init_pkg
//  Purpose  : Shared constants for the WM8731-style codec init sequencer:
//             table length, 7-bit register addresses, 9-bit register values,
//             the sequencer state encoding and a command packing helper.
//  Revision : 1.0  initial release
// ============================================================================
package codec_init_pkg;

    // Number of entries in the init table.
    localparam int NUM_CMDS = 11;

    // Codec register addresses (7 bits)
    localparam logic [6:0] REG_RESET      = 7'h0F;
    localparam logic [6:0] REG_L_LINE_IN  = 7'h00;
    localparam logic [6:0] REG_R_LINE_IN  = 7'h01;
    localparam logic [6:0] REG_L_HP       = 7'h02;
    localparam logic [6:0] REG_R_HP       = 7'h03;
    localparam logic [6:0] REG_ANALOG     = 7'h04;
    localparam logic [6:0] REG_DIGITAL    = 7'h05;
    localparam logic [6:0] REG_POWER      = 7'h06;
    localparam logic [6:0] REG_IFACE      = 7'h07;
    localparam logic [6:0] REG_SAMPLING   = 7'h08;
    localparam logic [6:0] REG_ACTIVE     = 7'h09;

    // Register values (9 bits)
    localparam logic [8:0] VAL_RESET      = 9'h000;
    localparam logic [8:0] VAL_LINE_IN    = 9'h017;
    localparam logic [8:0] VAL_HP         = 9'h079;
    localparam logic [8:0] VAL_ANALOG     = 9'h012;
    localparam logic [8:0] VAL_DIGITAL    = 9'h000;
    localparam logic [8:0] VAL_POWER      = 9'h000;
    localparam logic [8:0] VAL_IFACE      = 9'h002;  // I2S, 16-bit, slave
    localparam logic [8:0] VAL_SAMPLING   = 9'h000;
    localparam logic [8:0] VAL_ACTIVE     = 9'h001;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The codec wants the 9-bit value split across the two I2C bytes:
    // byte 0 = {addr[6:0], val[8]}, byte 1 = val[7:0].
    function automatic logic [15:0] pack_cmd(input logic [6:0] addr,
                                             input logic [8:0] val);
        return {addr, val};
    endfunction

endpackage
`default_nettype wire

// File: rtl/codec_init_rom.sv
`default_nettype none
// ============================================================================
//  Module   : codec_init_rom
//  Purpose  : Combinational lookup of the codec init table.
//  Ports    : index    in  IDX_W  table entry to read
//             sub_addr out 8      {reg_addr[6:0], reg_val[8]}
//             data     out 8      reg_val[7:0]
//  Revision : 1.0  initial release
// ============================================================================
module codec_init_rom #(
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] index,
    output logic [7:0]       sub_addr,
    output logic [7:0]       data
);
    import codec_init_pkg::*;

    logic [15:0] entry;

    always_comb begin
        entry = 16'h0000;
        case (int'(index))
            0:       entry = pack_cmd(REG_RESET,     VAL_RESET);
            1:       entry = pack_cmd(REG_L_LINE_IN, VAL_LINE_IN);
            2:       entry = pack_cmd(REG_R_LINE_IN, VAL_LINE_IN);
            3:       entry = pack_cmd(REG_L_HP,      VAL_HP);
            4:       entry = pack_cmd(REG_R_HP,      VAL_HP);
            5:       entry = pack_cmd(REG_ANALOG,    VAL_ANALOG);
            6:       entry = pack_cmd(REG_DIGITAL,   VAL_DIGITAL);
            7:       entry = pack_cmd(REG_POWER,     VAL_POWER);
            8:       entry = pack_cmd(REG_IFACE,     VAL_IFACE);
            9:       entry = pack_cmd(REG_SAMPLING,  VAL_SAMPLING);
            10:      entry = pack_cmd(REG_ACTIVE,    VAL_ACTIVE);
            default: entry = 16'h0000;
        endcase
    end

    assign sub_addr = entry[15:8];
    assign data     = entry[7:0];

endmodule
`default_nettype wire

// File: rtl/codec_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : codec_init_sequencer
//  Purpose  : Issues the codec register init sequence to an I2C write master,
//             one {sub-address, data} pair per rising edge of NewCom, then
//             idles until reset.
//  Ports    : I2C_clk  in  1  clock (rising edge)
//             reset    in  1  synchronous active-high reset
//             NewCom   in  1  master ready for next command (edge-detected)
//             write    out 1  one-cycle strobe, SubAddrL/data are new
//             SubAddrL out 8  {reg_addr[6:0], reg_val[8]}
//             data     out 8  reg_val[7:0]
//  Revision : 1.0  initial release
// ============================================================================
module codec_init_sequencer #(
    parameter int NUM_CMDS = codec_init_pkg::NUM_CMDS
) (
    input  logic       I2C_clk,
    input  logic       reset,
    input  logic       NewCom,
    output logic       write,
    output logic [7:0] SubAddrL,
    output logic [7:0] data
);
    import codec_init_pkg::*;

    // One extra code point so the index can reach NUM_CMDS without wrapping.
    localparam int IDX_W = $clog2(NUM_CMDS + 1);

    state_t           state, state_next;
    logic [IDX_W-1:0] index, index_next;
    logic             newcom_q;
    logic             rise;
    logic             write_next;
    logic [7:0]       sub_addr_next, data_next;
    logic [7:0]       rom_sub_addr, rom_data;

    codec_init_rom #(
        .IDX_W    (IDX_W)
    ) u_rom (
        .index    (index),
        .sub_addr (rom_sub_addr),
        .data     (rom_data)
    );

    // newcom_q clears on reset, so NewCom already high right after reset
    // is treated as a fresh request.
    assign rise = NewCom & ~newcom_q;

    always_ff @(posedge I2C_clk) begin
        if (reset) begin
            state    <= WAIT;
            index    <= '0;
            newcom_q <= 1'b0;
            write    <= 1'b0;
            SubAddrL <= 8'h00;
            data     <= 8'h00;
        end else begin
            state    <= state_next;
            index    <= index_next;
            newcom_q <= NewCom;
            write    <= write_next;
            SubAddrL <= sub_addr_next;
            data     <= data_next;
        end
    end

    always_comb begin
        state_next    = state;
        index_next    = index;
        write_next    = 1'b0;
        sub_addr_next = SubAddrL;
        data_next     = data;
        case (state)
            WAIT: begin
                if (rise) begin
                    sub_addr_next = rom_sub_addr;
                    data_next     = rom_data;
                    write_next    = 1'b1;
                    index_next    = index + 1'b1;
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                // index was already advanced when the command was issued.
                if (index == IDX_W'(NUM_CMDS))
                    state_next = DONE;
                else
                    state_next = WAIT;
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = WAIT;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_codec_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_codec_init_sequencer
//  Purpose  : Directed self-checking bench for codec_init_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_codec_init_sequencer;

    logic       I2C_clk;
    logic       reset;
    logic       NewCom;
    logic       write;
    logic [7:0] SubAddrL;
    logic [7:0] data;

    int checks = 0;
    int errors = 0;

    // Write-strobe monitor
    int          wr_count    = 0;
    int          long_pulses = 0;
    logic        prev_write  = 1'b0;
    logic [15:0] cap [0:15];
    logic [15:0] last_cap    = 16'h0000;

    // Expected init table, {SubAddrL, data}
    logic [15:0] exp_tab [0:10];

    codec_init_sequencer dut (
        .I2C_clk  (I2C_clk),
        .reset    (reset),
        .NewCom   (NewCom),
        .write    (write),
        .SubAddrL (SubAddrL),
        .data     (data)
    );

    initial I2C_clk = 1'b0;
    always #5 I2C_clk = ~I2C_clk;

    always @(negedge I2C_clk) begin
        if (write === 1'b1) begin
            if (wr_count < 16) cap[wr_count] = {SubAddrL, data};
            last_cap = {SubAddrL, data};
            wr_count = wr_count + 1;
            if (prev_write === 1'b1) long_pulses = long_pulses + 1;
        end
        prev_write = write;
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // NewCom high for one cycle; returns just after the edge on which the
    // DUT samples it, i.e. the edge that raises write.
    task automatic pulse();
        @(posedge I2C_clk); #1 NewCom = 1'b1;
        @(posedge I2C_clk); #1 NewCom = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge I2C_clk); #1 reset = 1'b1;
        repeat (cycles) @(posedge I2C_clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int base;
        exp_tab[0]  = 16'h1E00; exp_tab[1]  = 16'h0017; exp_tab[2]  = 16'h0217;
        exp_tab[3]  = 16'h0479; exp_tab[4]  = 16'h0679; exp_tab[5]  = 16'h0812;
        exp_tab[6]  = 16'h0A00; exp_tab[7]  = 16'h0C00; exp_tab[8]  = 16'h0E02;
        exp_tab[9]  = 16'h1000; exp_tab[10] = 16'h1201;

        reset  = 1'b1;
        NewCom = 1'b0;
        repeat (3) @(posedge I2C_clk);
        @(negedge I2C_clk);
        check("reset_write", 32'(write), 32'd0);
        check("reset_outs", 32'({SubAddrL, data}), 32'h0000);
        @(posedge I2C_clk); #1 reset = 1'b0;
        repeat (2) @(posedge I2C_clk);

        // First pulse: one-cycle strobe with entry 0
        base = wr_count;
        pulse();
        @(negedge I2C_clk);
        check("first_write_hi", 32'(write), 32'd1);
        check("first_outs", 32'({SubAddrL, data}), 32'h1E00);
        @(negedge I2C_clk);
        check("first_write_lo", 32'(write), 32'd0);
        check("first_hold", 32'({SubAddrL, data}), 32'h1E00);
        repeat (6) @(posedge I2C_clk);

        // Remaining entries, spaced 9 cycles apart
        for (int i = 1; i < 11; i++) begin
            pulse();
            repeat (7) @(posedge I2C_clk);
        end
        check("seq_count", 32'(wr_count - base), 32'd11);
        for (int i = 0; i < 11; i++)
            check($sformatf("seq_entry%0d", i), 32'(cap[base + i]), 32'(exp_tab[i]));

        // 24 more pulses are ignored in DONE
        for (int i = 0; i < 24; i++) begin
            pulse();
            repeat (7) @(posedge I2C_clk);
        end
        @(negedge I2C_clk);
        check("done_count", 32'(wr_count - base), 32'd11);
        check("done_hold", 32'({SubAddrL, data}), 32'h1201);
        check("done_write", 32'(write), 32'd0);

        // NewCom held high for 20 cycles -> one strobe
        do_reset(2);
        base = wr_count;
        @(posedge I2C_clk); #1 NewCom = 1'b1;
        repeat (20) @(posedge I2C_clk);
        #1 NewCom = 1'b0;
        repeat (4) @(posedge I2C_clk);
        check("held_count", 32'(wr_count - base), 32'd1);
        check("held_entry", 32'(last_cap), 32'h1E00);

        // Issue entries 1..4, then reset mid-sequence
        for (int i = 0; i < 4; i++) begin
            pulse();
            repeat (4) @(posedge I2C_clk);
        end
        check("mid_count", 32'(wr_count - base), 32'd5);
        check("mid_entry4", 32'(last_cap), 32'h0679);
        @(posedge I2C_clk); #1 reset = 1'b1;
        @(posedge I2C_clk);
        @(negedge I2C_clk);
        check("mid_reset_outs", 32'({write, SubAddrL, data}), 32'h00000);
        @(posedge I2C_clk); #1 reset = 1'b0;
        base = wr_count;
        pulse();
        repeat (3) @(posedge I2C_clk);
        check("restart_count", 32'(wr_count - base), 32'd1);
        check("restart_entry", 32'(last_cap), 32'h1E00);

        // NewCom rise coincident with reset is swallowed
        @(posedge I2C_clk); #1 reset = 1'b1; NewCom = 1'b1;
        @(posedge I2C_clk); #1 reset = 1'b0; NewCom = 1'b0;
        base = wr_count;
        repeat (4) @(posedge I2C_clk);
        check("rst_rise_nowrite", 32'(wr_count - base), 32'd0);
        pulse();
        repeat (3) @(posedge I2C_clk);
        check("rst_rise_next", 32'(wr_count - base), 32'd1);
        check("rst_rise_entry", 32'(last_cap), 32'h1E00);

        check("strobe_width", 32'(long_pulses), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        errors = errors + 1;
        $display("FAIL timeout: got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
